axaddr_gen: RTL and testbench
=============================

# axaddr_gen

Parametrised AXI read/write address-channel generator for the cnna DDR masters. A rising edge of `I_ap_start` launches a run that issues a programmed number of AXI bursts at a fixed stride from a base address, with `O_axvalid`/`I_axready` handshaking and a bounded number of outstanding bursts. It signals completion with a one-cycle `O_ap_done` once every burst has been accepted and retired. It sits between the layer-level control in `main_process` and the AR/AW channel of the `axim_rddr`/`axim_wddr` masters.

## Interface
- `AW`, 32, address width.
- `LW`, 8, AXI length field width.
- `NW`, 16, burst-count width.
- `BSIZE`, 4, log2 of bytes per beat.
- `OSTD`, 4, maximum outstanding bursts, range 1..255.

Ports:
- `I_clk` in 1: the only clock.
- `I_rst` in 1: synchronous, active-high reset.
- `I_ap_start` in 1: level run request. A rising edge starts a run; low aborts a run.
- `I_base_addr` in AW: first burst address.
- `I_req_num` in NW: number of bursts in the run.
- `I_burst_len` in LW: AXI len (beats-1), the same for every burst.
- `I_axready` in 1: slave ready.
- `I_resp_done` in 1: one-cycle pulse per retired burst (last R beat or B response).
- `O_axvalid` out 1: address valid.
- `O_axaddr` out AW: burst address.
- `O_axlen` out LW: burst length.
- `O_busy` out 1: high while the state is not IDLE.
- `O_ap_done` out 1: one-cycle completion pulse.

## Operation
- Start edge: `I_ap_start` high in the current cycle and low in the previous cycle (registered copy, cleared by reset). On the edge, `I_base_addr`, `I_req_num` and `I_burst_len` are latched. The inputs are ignored at all other times.
- Stride = (`I_burst_len`+1) << BSIZE. Burst k uses address base + k*stride, computed modulo 2^AW (wrap-around is silent). `O_axlen` equals the latched len.
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE → ISSUE on a start edge with `I_req_num`≠0.
  - IDLE → IDLE on a start edge with `I_req_num`=0. `O_ap_done` pulses the next cycle.
  - ISSUE → DRAIN when the last burst handshakes, or when `I_ap_start` is low and no valid is pending.
  - DRAIN → IDLE when the outstanding count is 0.
- Counters:
  - rem (NW) decrements on each handshake (`O_axvalid`&`I_axready`).
  - ostd (8 bits) increments on a handshake and decrements on `I_resp_done`. When both occur in the same cycle, ostd is unchanged. `I_resp_done` at ostd=0 is ignored (no underflow).
- `O_axvalid` is registered. Its next value is: state ISSUE, `I_ap_start` high, rem_next>0 and ostd_next<OSTD. This allows back-to-back bursts with no bubble while below OSTD.
- AXI rule: once `O_axvalid` is high it holds, with `O_axaddr`/`O_axlen` stable, until `I_axready`. This holds even if `I_ap_start` falls.
- Abort: when `I_ap_start` goes low in ISSUE, no new valid is raised. A pending valid completes its handshake, the block drains outstanding bursts, and returns to IDLE without `O_ap_done`.
- Normal completion: `O_ap_done` pulses for one cycle on the DRAIN→IDLE transition when rem=0 and no abort occurred.
- A start edge while not IDLE is ignored.

## Timing
- Reset values: `O_axvalid`=0, `O_axaddr`=0, `O_axlen`=0, `O_busy`=0, `O_ap_done`=0, state IDLE, rem=0, ostd=0, start-edge register=0.
- Reset mid-run drops `O_axvalid` in the next cycle. This is the only permitted valid drop without ready.
- Latency: start edge in cycle 0 gives first `O_axvalid` in cycle 1 and `O_busy` from cycle 1.
- With `I_axready` tied high and OSTD not reached, one burst is issued per cycle.
- `O_ap_done` comes one cycle after the cycle in which ostd reaches 0 with rem=0.

## Configuration
- `AXADDR_GEN_STALL_CNT_EN`
  - Defined: adds output `O_stall_cnt` [31:0]. It counts cycles with `O_axvalid`&!`I_axready` in the current run, is cleared on a start edge and on reset, and saturates at 0xFFFFFFFF.
  - Undefined: the port and the counter are absent. All other behaviour is identical.

## Test plan
- Base 0x1000, req 4, len 15, BSIZE 4, ready=1, each `I_resp_done` 3 cycles after its handshake → addresses 0x1000/0x1100/0x1200/0x1300 in cycles 1-4; `O_ap_done` one cycle after the 4th retire.
- OSTD=2, req 5, no `I_resp_done` → exactly 2 handshakes, then `O_axvalid` stays low. One `I_resp_done` pulse → the 3rd burst is issued the cycle after.
- Ready held low for 5 cycles, `I_ap_start` dropped during the stall → valid and address stay stable until ready; no further bursts; no `O_ap_done`; `O_busy` clears after the outstanding burst retires.
- req 0 → no `O_axvalid`; `O_ap_done` in cycle 1.
- Base 0xFFFFFF00, AW=32, req 2, len 15, BSIZE 4 → addresses 0xFFFFFF00, then 0x00000000.
- Same-cycle handshake and `I_resp_done`, a spurious `I_resp_done` at ostd=0, and `I_rst` asserted mid-run → ostd unchanged, no underflow, and all outputs at their reset values one cycle after reset.

Source files
------------

// File: rtl/axaddr_gen_if.sv
// axaddr_gen_if: AXI address-channel bundle between the address generator
// and the AR/AW side of a DDR master.
//   master modport: the generator (drives valid/addr/len).
//   slave  modport: the DDR master (drives ready and the retire pulse).
interface axaddr_gen_if #(
  parameter int AW = 32,
  parameter int LW = 8
);
  logic          axvalid;
  logic [AW-1:0] axaddr;
  logic [LW-1:0] axlen;
  logic          axready;
  logic          resp_done;  // one pulse per retired burst

  modport master (
    output axvalid, axaddr, axlen,
    input  axready, resp_done
  );

  modport slave (
    input  axvalid, axaddr, axlen,
    output axready, resp_done
  );
endinterface

// File: rtl/axaddr_gen.sv
// axaddr_gen: issues I_req_num AXI bursts of I_burst_len+1 beats starting at
// I_base_addr with a stride of one burst, keeping at most OSTD bursts
// outstanding, and pulses O_ap_done once all bursts are accepted and retired.
// A low I_ap_start during issue aborts: the pending burst completes, the
// outstanding bursts drain, and no O_ap_done is produced.
// Optional feature: define AXADDR_GEN_STALL_CNT_EN to add O_stall_cnt, a
// saturating per-run count of cycles where valid is held without ready.
module axaddr_gen #(
  parameter int AW    = 32,
  parameter int LW    = 8,
  parameter int NW    = 16,
  parameter int BSIZE = 4,
  parameter int OSTD  = 4
) (
  input  logic            I_clk,
  input  logic            I_rst,
  input  logic            I_ap_start,
  input  logic [AW-1:0]   I_base_addr,
  input  logic [NW-1:0]   I_req_num,
  input  logic [LW-1:0]   I_burst_len,
  axaddr_gen_if.master    ax,
  output logic            O_busy,
  output logic            O_ap_done
`ifdef AXADDR_GEN_STALL_CNT_EN
  ,
  output logic [31:0]     O_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [NW-1:0] REM_ONE  = {{(NW-1){1'b0}}, 1'b1};
  localparam logic [NW-1:0] REM_ZERO = '0;
  localparam logic [7:0]    OSTD_LIM = 8'(OSTD);
  localparam logic [7:0]    OSTD_ONE = 8'd1;

  state_t        state_q, state_d;
  logic          start_q;
  logic [NW-1:0] rem_q, rem_d;
  logic [7:0]    ostd_q, ostd_d;
  logic          valid_q, valid_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] len_q, len_d;
  logic          done_q, done_d;
  logic          abort_q, abort_d;

  logic          start_edge;
  logic          hs;
  logic          rd_ok;
  logic [AW-1:0] stride;

  assign start_edge = I_ap_start & ~start_q;
  assign hs         = valid_q & ax.axready;
  // A retire pulse with nothing outstanding is spurious and must not underflow.
  assign rd_ok      = ax.resp_done & (ostd_q != 8'd0);
  // Wrap-around of the address is intentional and silent.
  assign stride     = ({{(AW-LW){1'b0}}, len_q} + ADDR_ONE) << BSIZE;

  // Next-state, counter and address-channel decode.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned; that is what keeps this block from inferring latches.
    state_d = state_q;
    rem_d   = rem_q;
    ostd_d  = ostd_q;
    addr_d  = addr_q;
    len_d   = len_q;
    abort_d = abort_q;
    done_d  = 1'b0;
    valid_d = 1'b0;

    if (hs) begin
      rem_d = rem_q - REM_ONE;
    end

    unique case ({hs, rd_ok})
      2'b10:   ostd_d = ostd_q + OSTD_ONE;
      2'b01:   ostd_d = ostd_q - OSTD_ONE;
      default: ostd_d = ostd_q;
    endcase

    unique case (state_q)
      IDLE: begin
        if (start_edge) begin
          if (I_req_num != REM_ZERO) begin
            state_d = ISSUE;
            rem_d   = I_req_num;
            addr_d  = I_base_addr;
            len_d   = I_burst_len;
            abort_d = 1'b0;
          end else begin
            done_d  = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (hs) begin
          addr_d = addr_q + stride;
        end
        if (hs && (rem_q == REM_ONE)) begin
          state_d = DRAIN;
        end else if (!I_ap_start && !valid_q) begin
          state_d = DRAIN;
          abort_d = 1'b1;
        end
      end
      DRAIN: begin
        if (ostd_d == 8'd0) begin
          state_d = IDLE;
          done_d  = (rem_q == REM_ZERO) && !abort_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // A raised valid holds until accepted, even across an abort.
    if (valid_q && !ax.axready) begin
      valid_d = 1'b1;
    end else begin
      valid_d = (state_d == ISSUE) && I_ap_start &&
                (rem_d != REM_ZERO) && (ostd_d < OSTD_LIM);
    end
  end

  // State and datapath registers.
  always_ff @(posedge I_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (I_rst) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      rem_q   <= '0;
      ostd_q  <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= I_ap_start;
      rem_q   <= rem_d;
      ostd_q  <= ostd_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

  assign ax.axvalid = valid_q;
  assign ax.axaddr  = addr_q;
  assign ax.axlen   = len_q;
  assign O_busy     = (state_q != IDLE);
  assign O_ap_done  = done_q;

`ifdef AXADDR_GEN_STALL_CNT_EN
  logic [31:0] stall_q;

  // Saturating count of back-pressured cycles in the current run.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      stall_q <= '0;
    end else if ((state_q == IDLE) && start_edge) begin
      stall_q <= '0;
    end else if (valid_q && !ax.axready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign O_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_axaddr_gen.sv
// tb_axaddr_gen: directed bench for axaddr_gen. Two instances share the clock:
// dut_a with OSTD=4 and dut_b with OSTD=2. Inputs change 1 ns after each rising
// edge, and outputs are sampled at the same point, so "cycle c" below means the
// clock period that follows the c-th edge after the start request.
module tb_axaddr_gen;

  logic clk;
  logic rst;

  logic        start_a, start_b;
  logic [31:0] base_a, base_b;
  logic [15:0] req_a, req_b;
  logic [7:0]  len_a, len_b;
  logic        busy_a, busy_b;
  logic        done_a, done_b;
`ifdef AXADDR_GEN_STALL_CNT_EN
  logic [31:0] stall_a, stall_b;
`endif

  int n_chk = 0;
  int n_bad = 0;
  int hs_cnt;

  axaddr_gen_if #(.AW(32), .LW(8)) bus_a ();
  axaddr_gen_if #(.AW(32), .LW(8)) bus_b ();

  axaddr_gen #(.AW(32), .LW(8), .NW(16), .BSIZE(4), .OSTD(4)) dut_a (
    .I_clk       (clk),
    .I_rst       (rst),
    .I_ap_start  (start_a),
    .I_base_addr (base_a),
    .I_req_num   (req_a),
    .I_burst_len (len_a),
    .ax          (bus_a),
    .O_busy      (busy_a),
    .O_ap_done   (done_a)
`ifdef AXADDR_GEN_STALL_CNT_EN
    ,
    .O_stall_cnt (stall_a)
`endif
  );

  axaddr_gen #(.AW(32), .LW(8), .NW(16), .BSIZE(4), .OSTD(2)) dut_b (
    .I_clk       (clk),
    .I_rst       (rst),
    .I_ap_start  (start_b),
    .I_base_addr (base_b),
    .I_req_num   (req_b),
    .I_burst_len (len_b),
    .ax          (bus_b),
    .O_busy      (busy_b),
    .O_ap_done   (done_b)
`ifdef AXADDR_GEN_STALL_CNT_EN
    ,
    .O_stall_cnt (stall_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0; base_a = '0; req_a = '0; len_a = '0;
    start_b = 1'b0; base_b = '0; req_b = '0; len_b = '0;
    bus_a.axready = 1'b0; bus_a.resp_done = 1'b0;
    bus_b.axready = 1'b0; bus_b.resp_done = 1'b0;
    tick();
    tick();

    // Reset state.
    check("rst_valid", bus_a.axvalid, 1'b0);
    check("rst_addr",  bus_a.axaddr,  32'h0);
    check("rst_len",   bus_a.axlen,   8'h0);
    check("rst_busy",  busy_a,        1'b0);
    check("rst_done",  done_a,        1'b0);
    check("rst_b_valid", bus_b.axvalid, 1'b0);
    rst = 1'b0;
    tick();

    // Test 1: 4 bursts, ready high, each retired 3 cycles after acceptance.
    base_a = 32'h1000; req_a = 16'd4; len_a = 8'd15;
    bus_a.axready = 1'b1; start_a = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      bus_a.resp_done = (c >= 4 && c <= 7);
      check($sformatf("t1_valid_c%0d", c), bus_a.axvalid, (c <= 4));
      if (c <= 4)
        check($sformatf("t1_addr_c%0d", c), bus_a.axaddr,
              32'h1000 + 32'(c - 1) * 32'h100);
      check($sformatf("t1_busy_c%0d", c), busy_a, (c <= 7));
      check($sformatf("t1_done_c%0d", c), done_a, (c == 8));
      if (c == 1) check("t1_len", bus_a.axlen, 8'd15);
    end
    start_a = 1'b0;
    tick();

    // Test 2: OSTD=2, 5 requested, no retires -> only 2 issued; one retire
    // lets the third go the next cycle; then abort and drain.
    base_b = 32'h2000; req_b = 16'd5; len_b = 8'd0;
    bus_b.axready = 1'b1; start_b = 1'b1;
    hs_cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      bus_b.resp_done = (c == 6 || c == 8 || c == 9);
      if (c == 8) start_b = 1'b0;
      if (c <= 6 && bus_b.axvalid && bus_b.axready) hs_cnt++;
      check($sformatf("t2_valid_c%0d", c), bus_b.axvalid, (c <= 2 || c == 7));
      if (c == 2) check("t2_addr_c2", bus_b.axaddr, 32'h2010);
      if (c == 7) check("t2_addr_c7", bus_b.axaddr, 32'h2020);
      check($sformatf("t2_busy_c%0d", c), busy_b, (c <= 9));
      check($sformatf("t2_done_c%0d", c), done_b, 1'b0);
    end
    check("t2_hs_count", 32'(hs_cnt), 32'd2);
    tick();

    // Test 3: ready low for 5 cycles, start dropped during the stall.
    base_a = 32'h3000; req_a = 16'd3; len_a = 8'd1;
    bus_a.axready = 1'b0; start_a = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 3) start_a = 1'b0;
      bus_a.axready   = (c >= 6);
      bus_a.resp_done = (c == 8);
      check($sformatf("t3_valid_c%0d", c), bus_a.axvalid, (c <= 6));
      if (c <= 6) check($sformatf("t3_addr_c%0d", c), bus_a.axaddr, 32'h3000);
      check($sformatf("t3_busy_c%0d", c), busy_a, (c <= 8));
      check($sformatf("t3_done_c%0d", c), done_a, 1'b0);
    end
    bus_a.resp_done = 1'b0;
    tick();

    // Test 4: zero bursts -> done in cycle 1, never valid, never busy.
    req_a = 16'd0; start_a = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      tick();
      check($sformatf("t4_done_c%0d", c), done_a, (c == 1));
      check($sformatf("t4_valid_c%0d", c), bus_a.axvalid, 1'b0);
      check($sformatf("t4_busy_c%0d", c), busy_a, 1'b0);
    end
    start_a = 1'b0;
    tick();

    // Test 5: address wrap-around.
    base_a = 32'hFFFF_FF00; req_a = 16'd2; len_a = 8'd15;
    bus_a.axready = 1'b1; start_a = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 3) start_a = 1'b0;
      bus_a.resp_done = (c == 3 || c == 4);
      check($sformatf("t5_valid_c%0d", c), bus_a.axvalid, (c <= 2));
      if (c == 1) check("t5_addr_c1", bus_a.axaddr, 32'hFFFF_FF00);
      if (c == 2) check("t5_addr_c2", bus_a.axaddr, 32'h0000_0000);
      check($sformatf("t5_busy_c%0d", c), busy_a, (c <= 4));
      check($sformatf("t5_done_c%0d", c), done_a, (c == 5));
    end
    bus_a.resp_done = 1'b0;
    tick();

    // Test 6a: spurious retire while idle, then a run with a retire in the
    // same cycle as a handshake; exactly two more retires must finish it.
    bus_a.resp_done = 1'b1;
    tick();
    bus_a.resp_done = 1'b0;
    base_a = 32'h4000; req_a = 16'd3; len_a = 8'd15; start_a = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      bus_a.resp_done = (c == 2 || c == 4 || c == 5);
      if (c == 4) start_a = 1'b0;
      check($sformatf("t6_valid_c%0d", c), bus_a.axvalid, (c <= 3));
      if (c <= 3)
        check($sformatf("t6_addr_c%0d", c), bus_a.axaddr,
              32'h4000 + 32'(c - 1) * 32'h100);
      check($sformatf("t6_busy_c%0d", c), busy_a, (c <= 5));
      check($sformatf("t6_done_c%0d", c), done_a, (c == 6));
    end
    bus_a.resp_done = 1'b0;
    tick();

    // Test 6b: reset in the middle of a run.
    base_a = 32'h5000; req_a = 16'd4; len_a = 8'd15; start_a = 1'b1;
    tick();
    check("t7_valid_c1", bus_a.axvalid, 1'b1);
    tick();
    check("t7_addr_c2", bus_a.axaddr, 32'h5100);
    rst = 1'b1; start_a = 1'b0;
    tick();
    check("t7_rst_valid", bus_a.axvalid, 1'b0);
    check("t7_rst_addr",  bus_a.axaddr,  32'h0);
    check("t7_rst_len",   bus_a.axlen,   8'h0);
    check("t7_rst_busy",  busy_a,        1'b0);
    check("t7_rst_done",  done_a,        1'b0);
    rst = 1'b0;
    tick();

    // A single-burst run after reset needs exactly one retire.
    base_a = 32'h6000; req_a = 16'd1; len_a = 8'd0; start_a = 1'b1;
    tick();
    check("t8_valid_c1", bus_a.axvalid, 1'b1);
    check("t8_addr_c1",  bus_a.axaddr,  32'h6000);
    tick();
    bus_a.resp_done = 1'b1;
    check("t8_valid_c2", bus_a.axvalid, 1'b0);
    tick();
    bus_a.resp_done = 1'b0;
    start_a = 1'b0;
    check("t8_done_c3", done_a, 1'b1);
    check("t8_busy_c3", busy_a, 1'b0);
    tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
